// File: rtl/segment_pkg.sv
// ============================================================================
// Module      : segment_pkg
// Description : Shared constants and register-map helpers for segment_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package segment_pkg;

    localparam int PWM_BITS = 4;

    localparam logic [PWM_BITS-1:0] BRIGHT_RST = 4'd15;
    localparam logic                CTRL_RST   = 1'b1;

    // Control registers sit directly above the NUM_DIGITS digit bytes.
    function automatic logic [3:0] blink_addr(input int n);
        return 4'(n);
    endfunction

    function automatic logic [3:0] bright_addr(input int n);
        return 4'(n + 1);
    endfunction

    function automatic logic [3:0] ctrl_addr(input int n);
        return 4'(n + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/segment_scan_ctrl_if.sv
// ============================================================================
// Module      : segment_scan_ctrl_if
// Description : 8-bit Avalon-MM register bus between CPU and segment_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface segment_scan_ctrl_if;

    logic [3:0] slave_address;
    logic       slave_read;
    logic       slave_write;
    logic [7:0] slave_writedata;
    logic [7:0] slave_readdata;

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        input  slave_readdata
    );

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        output slave_readdata
    );

endinterface

`default_nettype wire

// File: rtl/segment_scan_timer.sv
// ============================================================================
// Module      : segment_scan_timer
// Description : Free-running prescaler, digit index, blink phase and PWM phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_scan_timer
    import segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_LOG2 = 17,
    parameter int BLINK_LOG2    = 9,
    parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    output logic [IDX_W-1:0]         o_digit_idx,
    output logic                     o_blink_phase,
    output logic [PWM_BITS-1:0]      o_pwm_phase
);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_DIV_LOG2-1:0] r_presc;
    logic [IDX_W-1:0]         r_idx;
    logic [BLINK_LOG2-1:0]    r_blink_cnt;
    logic                     r_blink_phase;
    logic                     w_tick;

    // Tick is the last prescaler count, so everything advances as it wraps to 0.
    assign w_tick = &r_presc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_presc <= r_presc + SCAN_DIV_LOG2'(1);
            if (w_tick) begin
                if (r_idx == c_idx_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
                if (&r_blink_cnt) begin
                    r_blink_phase <= ~r_blink_phase;
                end
            end
        end
    end

    assign o_digit_idx   = r_idx;
    assign o_blink_phase = r_blink_phase;
    assign o_pwm_phase   = r_presc[SCAN_DIV_LOG2-1 -: PWM_BITS];

endmodule

`default_nettype wire

// File: rtl/segment_scan_ctrl.sv
// ============================================================================
// Module      : segment_scan_ctrl
// Description : Multiplexed seven-segment controller with Avalon-MM registers,
//               brightness PWM and per-digit blink. Define SEG_READBACK_EN to
//               enable register readback; otherwise slave_readdata is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_scan_ctrl
    import segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_LOG2 = 17,
    parameter int BLINK_LOG2    = 9,
    parameter int EN_ACTIVE_LOW = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    segment_scan_ctrl_if.slave     avs,
    output logic [7:0]             seg_data,
    output logic [NUM_DIGITS-1:0]  digit_en
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [3:0] c_blink_addr  = blink_addr(NUM_DIGITS);
    localparam logic [3:0] c_bright_addr = bright_addr(NUM_DIGITS);
    localparam logic [3:0] c_ctrl_addr   = ctrl_addr(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_en_off = (EN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_DIGITS-1:0][7:0] r_digit;
    logic [NUM_DIGITS-1:0]      r_blink_mask;
    logic [PWM_BITS-1:0]        r_bright;
    logic                       r_enable;

    logic [IDX_W-1:0]           w_digit_idx;
    logic                       w_blink_phase;
    logic [PWM_BITS-1:0]        w_pwm_phase;

    logic [7:0]                 w_cur_seg;
    logic                       w_cur_blink;
    logic [NUM_DIGITS-1:0]      w_onehot;
    logic                       w_visible;

    logic [7:0]                 r_seg_data;
    logic [NUM_DIGITS-1:0]      r_digit_en;

    segment_scan_timer #(
        .NUM_DIGITS    (NUM_DIGITS),
        .SCAN_DIV_LOG2 (SCAN_DIV_LOG2),
        .BLINK_LOG2    (BLINK_LOG2),
        .IDX_W         (IDX_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .o_digit_idx   (w_digit_idx),
        .o_blink_phase (w_blink_phase),
        .o_pwm_phase   (w_pwm_phase)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit      <= '0;
            r_blink_mask <= '0;
            r_bright     <= BRIGHT_RST;
            r_enable     <= CTRL_RST;
        end else if (avs.slave_write) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs.slave_address == 4'(i)) begin
                    r_digit[i] <= avs.slave_writedata;
                end
            end
            if (avs.slave_address == c_blink_addr) begin
                r_blink_mask <= avs.slave_writedata[NUM_DIGITS-1:0];
            end
            if (avs.slave_address == c_bright_addr) begin
                r_bright <= avs.slave_writedata[PWM_BITS-1:0];
            end
            if (avs.slave_address == c_ctrl_addr) begin
                r_enable <= avs.slave_writedata[0];
            end
        end
    end

`ifdef SEG_READBACK_EN
    logic [7:0] w_rdata;
    logic [7:0] r_rdata;

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avs.slave_address == 4'(i)) begin
                w_rdata = r_digit[i];
            end
        end
        if (avs.slave_address == c_blink_addr) begin
            w_rdata = 8'(r_blink_mask);
        end
        if (avs.slave_address == c_bright_addr) begin
            w_rdata = 8'(r_bright);
        end
        if (avs.slave_address == c_ctrl_addr) begin
            w_rdata = {7'b0, r_enable};
        end
    end

    // Sampled from pre-write register state, so a same-cycle write is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (avs.slave_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign avs.slave_readdata = r_rdata;
`else
    logic w_unused_read;
    assign w_unused_read      = avs.slave_read;
    assign avs.slave_readdata = '0;
`endif

    always_comb begin
        w_cur_seg   = '0;
        w_cur_blink = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit_idx == IDX_W'(i)) begin
                w_cur_seg   = r_digit[i];
                w_cur_blink = r_blink_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Blinking digits are lit only in the second half of each blink period.
    assign w_visible = r_enable
                     && (w_pwm_phase <= r_bright)
                     && (!w_cur_blink || w_blink_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_data <= '0;
            r_digit_en <= c_en_off;
        end else if (w_visible) begin
            r_seg_data <= w_cur_seg;
            r_digit_en <= w_onehot ^ c_en_off;
        end else begin
            r_seg_data <= '0;
            r_digit_en <= c_en_off;
        end
    end

    assign seg_data = r_seg_data;
    assign digit_en = r_digit_en;

endmodule

`default_nettype wire

// File: tb/tb_segment_scan_ctrl.sv
// ============================================================================
// Module      : tb_segment_scan_ctrl
// Description : Self-checking bench for segment_scan_ctrl (4 digits, fast scan).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_segment_scan_ctrl;

    localparam int ND   = 4;
    localparam int SDL  = 4;
    localparam int BL   = 1;
    localparam int SLOT = 1 << SDL;
`ifdef SEG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    seg_data;
    logic [ND-1:0] digit_en;

    segment_scan_ctrl_if avs ();

    segment_scan_ctrl #(
        .NUM_DIGITS    (ND),
        .SCAN_DIV_LOG2 (SDL),
        .BLINK_LOG2    (BL),
        .EN_ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (avs),
        .seg_data (seg_data),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters derived from elapsed clocks since reset.
    int            t = 0;
    logic [7:0]    m_digit [ND] = '{default: 8'h00};
    logic [ND-1:0] m_mask   = '0;
    logic [3:0]    m_bright = 4'd15;
    logic          m_ctrl   = 1'b1;
    logic [7:0]    exp_seg  = 8'h00;
    logic [ND-1:0] exp_en   = '1;
    logic [7:0]    exp_rd   = 8'h00;
    int            m_slot, m_pos, m_idx, m_addr;
    bit            m_vis;

    function automatic logic [7:0] m_reg(input int a);
        if (a < ND)     return m_digit[a];
        if (a == ND)    return 8'(m_mask);
        if (a == ND + 1) return 8'(m_bright);
        if (a == ND + 2) return {7'b0, m_ctrl};
        return 8'h00;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t        = 0;
            m_digit  = '{default: 8'h00};
            m_mask   = '0;
            m_bright = 4'd15;
            m_ctrl   = 1'b1;
            exp_seg  = 8'h00;
            exp_en   = '1;
            exp_rd   = 8'h00;
        end else begin
            m_slot = t / SLOT;
            m_pos  = t % SLOT;
            m_idx  = m_slot % ND;
            m_vis  = m_ctrl && ((m_pos >> (SDL - 4)) <= int'(m_bright))
                     && (!m_mask[m_idx] || (((m_slot >> BL) % 2) == 1));
            exp_seg = m_vis ? m_digit[m_idx] : 8'h00;
            exp_en  = m_vis ? ~(ND'(1) << m_idx) : '1;
            m_addr  = int'(avs.slave_address);
            if (avs.slave_read) exp_rd = RB ? m_reg(m_addr) : 8'h00;
            if (avs.slave_write) begin
                if (m_addr < ND)          m_digit[m_addr] = avs.slave_writedata;
                else if (m_addr == ND)     m_mask   = avs.slave_writedata[ND-1:0];
                else if (m_addr == ND + 1) m_bright = avs.slave_writedata[3:0];
                else if (m_addr == ND + 2) m_ctrl   = avs.slave_writedata[0];
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("seg_data", 32'(seg_data), 32'(exp_seg));
            chk("digit_en", 32'(digit_en), 32'(exp_en));
            chk("readdata", 32'(avs.slave_readdata), 32'(exp_rd));
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        avs.slave_address   = a;
        avs.slave_writedata = d;
        avs.slave_read      = rd;
        avs.slave_write     = wr;
        @(posedge clk);
        #1;
        avs.slave_read  = 1'b0;
        avs.slave_write = 1'b0;
    endtask

    task automatic count_lit(input int cycles, output int n_any, output int n0,
                             output int n1, output int n2);
        n_any = 0; n0 = 0; n1 = 0; n2 = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (digit_en != 4'hF)    n_any++;
            if (digit_en == 4'b1110) n0++;
            if (digit_en == 4'b1101) n1++;
            if (digit_en == 4'b1011) n2++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int na, n0, n1, n2;
        bit found;
        avs.slave_address = '0; avs.slave_writedata = '0;
        avs.slave_read = 1'b0;  avs.slave_write = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 32'(digit_en), 32'hF);
        chk("rst_seg", 32'(seg_data), 32'h0);
        chk("rst_rd", 32'(avs.slave_readdata), 32'h0);
        cmp_on = 1'b1;
        reset  = 1'b0;

        @(posedge clk); @(negedge clk);
        chk("first_slot_en", 32'(digit_en), 32'hE);
        repeat (SLOT) @(negedge clk);
        chk("second_slot_en", 32'(digit_en), 32'hD);

        bus(1'b0, 1'b1, 4'd2, 8'h3F);
        bus(1'b1, 1'b0, 4'd2, 8'h00);
        chk("rd_digit2", 32'(avs.slave_readdata), RB ? 32'h3F : 32'h0);

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (digit_en == 4'b1011) found = 1'b1;
        end
        chk("digit2_seen", 32'(found), 32'h1);
        chk("digit2_seg", 32'(seg_data), 32'h3F);

        bus(1'b1, 1'b1, 4'd2, 8'h55);
        chk("rdwr_prewrite", 32'(avs.slave_readdata), RB ? 32'h3F : 32'h0);
        bus(1'b1, 1'b0, 4'd2, 8'h00);
        chk("rd_after_wr", 32'(avs.slave_readdata), RB ? 32'h55 : 32'h0);

        bus(1'b0, 1'b1, 4'd5, 8'h03);
        @(posedge clk);
        count_lit(64, na, n0, n1, n2);
        chk("bright3_lit", 32'(na), 32'd16);

        bus(1'b0, 1'b1, 4'd4, 8'h05);
        @(posedge clk);
        count_lit(64, na, n0, n1, n2);
        chk("blink_d0_dark", 32'(n0), 32'd0);
        chk("blink_d1_plain", 32'(n1), 32'd4);
        chk("blink_d2_phase1", 32'(n2), 32'd4);
        bus(1'b0, 1'b1, 4'd4, 8'h00);

        bus(1'b0, 1'b1, 4'd6, 8'h00);
        @(posedge clk); @(negedge clk);
        chk("disable_en", 32'(digit_en), 32'hF);
        chk("disable_seg", 32'(seg_data), 32'h0);
        count_lit(32, na, n0, n1, n2);
        chk("disable_dark", 32'(na), 32'd0);
        bus(1'b0, 1'b1, 4'd6, 8'h01);
        @(posedge clk);
        count_lit(64, na, n0, n1, n2);
        chk("reenable_lit", 32'(na), 32'd16);

        bus(1'b1, 1'b0, 4'd9, 8'h00);
        chk("rd_unmapped", 32'(avs.slave_readdata), 32'h0);
        bus(1'b0, 1'b1, 4'd12, 8'hFF);
        bus(1'b1, 1'b0, 4'd2, 8'h00);
        chk("wr_unmapped_d2", 32'(avs.slave_readdata), RB ? 32'h55 : 32'h0);
        bus(1'b1, 1'b0, 4'd5, 8'h00);
        chk("rd_bright", 32'(avs.slave_readdata), RB ? 32'h03 : 32'h0);

        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_en", 32'(digit_en), 32'hF);
        chk("async_rst_seg", 32'(seg_data), 32'h0);
        chk("async_rst_rd", 32'(avs.slave_readdata), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("restart_en", 32'(digit_en), 32'hE);
        bus(1'b1, 1'b0, 4'd6, 8'h00);
        chk("rd_ctrl_rst", 32'(avs.slave_readdata), RB ? 32'h1 : 32'h0);

        repeat (5) @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
